// File: rtl/prng_pkg.sv
// Shared types and constants for the dice random-number source and its display stage.
package prng_pkg;

    localparam int unsigned VALUE_W          = 8;
    localparam int unsigned DEFAULT_TICK_DIV = 10_000_000;
    localparam logic [VALUE_W-1:0] LFSR_TAPS    = 8'hB8;
    localparam logic [VALUE_W-1:0] DEFAULT_SEED = 8'hA5;

    typedef enum logic [1:0] {
        IDLE,
        ROLL,
        SHOW
    } state_e;

    // One Galois step; an all-zero register is a lock-up state, so reload the seed instead.
    function automatic logic [VALUE_W-1:0] lfsr_next(
        input logic [VALUE_W-1:0] cur,
        input logic [VALUE_W-1:0] seed
    );
        if (cur == '0) begin
            return seed;
        end else if (cur[0]) begin
            return (cur >> 1) ^ LFSR_TAPS;
        end else begin
            return cur >> 1;
        end
    endfunction

endpackage

// File: rtl/prng_roll_core_if.sv
// Roll button and result bus between the random-number core and its consumer.
interface prng_roll_core_if;
    import prng_pkg::*;

    logic               en;
    logic [VALUE_W-1:0] value;
    logic               valid;
    logic               tick;
    logic               rolling;

    modport master (
        output en,
        input  value,
        input  valid,
        input  tick,
        input  rolling
    );

    modport slave (
        input  en,
        output value,
        output valid,
        output tick,
        output rolling
    );

endinterface

// File: rtl/prng_roll_core_tick_div.sv
// Free-running divider: one-cycle registered strobe every TICK_DIV clocks.
module tick_div #(
    parameter int unsigned TICK_DIV = 10_000_000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int unsigned CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap = (r_cnt == CNT_MAX);

    // Strobe is set on the same edge the counter wraps to zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
            r_tick <= w_wrap;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/prng_roll_core.sv
// Dice random-number source: free-running LFSR, EN synchroniser and roll/hold state machine.
module prng_roll_core
    import prng_pkg::*;
#(
    parameter int unsigned        TICK_DIV = DEFAULT_TICK_DIV,
    parameter logic [VALUE_W-1:0] SEED     = DEFAULT_SEED
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    prng_roll_core_if.slave  bus
);

    logic [VALUE_W-1:0] r_lfsr;
    logic               r_s1;
    logic               r_s2;
    logic               r_s2_d;
    state_e             r_state;
    logic [VALUE_W-1:0] r_value;
    logic               r_valid;
    logic               r_rolling;
    logic               w_tick;
    logic               w_rise;
    logic               w_fall;

    tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_div (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_tick  (w_tick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= lfsr_next(r_lfsr, SEED);
        end
    end

    // EN is an asynchronous button: two-flop synchroniser plus an edge-detect delay.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_s2_d <= 1'b0;
        end else begin
            r_s1   <= bus.en;
            r_s2   <= r_s1;
            r_s2_d <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s2_d;
    assign w_fall = ~r_s2 & r_s2_d;

    // A fall wins over a coincident tick; both would latch the same pre-step LFSR value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_value   <= '0;
            r_valid   <= 1'b0;
            r_rolling <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        r_state   <= ROLL;
                        r_rolling <= 1'b1;
                    end
                end
                ROLL: begin
                    if (w_fall) begin
                        r_state   <= SHOW;
                        r_value   <= r_lfsr;
                        r_valid   <= 1'b1;
                        r_rolling <= 1'b0;
                    end else if (w_tick) begin
                        r_value <= r_lfsr;
                    end
                end
                SHOW: begin
                    if (w_rise) begin
                        r_state   <= ROLL;
                        r_rolling <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_rolling <= 1'b0;
                end
            endcase
        end
    end

    assign bus.value   = r_value;
    assign bus.valid   = r_valid;
    assign bus.tick    = w_tick;
    assign bus.rolling = r_rolling;

endmodule

// File: tb/tb_prng_roll_core.sv
// Directed bench for prng_roll_core with TICK_DIV = 4 and SEED = A5.
module tb_prng_roll_core;

    localparam int unsigned TB_TICK_DIV = 4;
    localparam logic [7:0]  TB_SEED     = 8'hA5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_n  = 0;

    always #5 clk = ~clk;

    prng_roll_core_if bus_if ();

    prng_roll_core #(
        .TICK_DIV (TB_TICK_DIV),
        .SEED     (TB_SEED)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_if)
    );

    typedef struct {
        logic       en;
        logic [7:0] value;
        logic       valid;
        logic       tick;
        logic       rolling;
    } vec_t;

    vec_t vecs [21];

    function automatic logic [7:0] ref_lfsr(input logic [7:0] s);
        logic [7:0] n;
        if (s == 8'h00) begin
            n = TB_SEED;
        end else begin
            n = {1'b0, s[7:1]};
            if (s[0]) n = n ^ 8'hB8;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %02h, want %02h", name, edge_n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Releases reset between edges so the next rising edge is edge 1.
    task automatic reset_release();
        bus_if.en = 1'b0;
        rst_n     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".value"},   bus_if.value,         8'h00);
        check({tag, ".valid"},   8'(bus_if.valid),     8'h00);
        check({tag, ".tick"},    8'(bus_if.tick),      8'h00);
        check({tag, ".rolling"}, 8'(bus_if.rolling),   8'h00);
    endtask

    function automatic vec_t mk(input logic en, input logic [7:0] v, input logic va,
                                input logic tk, input logic rl);
        vec_t r;
        r.en = en; r.value = v; r.valid = va; r.tick = tk; r.rolling = rl;
        return r;
    endfunction

    initial begin
        logic [7:0] m_lfsr;
        logic [7:0] exp_val;
        bit         saw_valid;

        bus_if.en = 1'b0;

        // Short roll, then re-roll from SHOW ending with a fall coincident with a tick.
        vecs[0]  = mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        vecs[3]  = mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        vecs[4]  = mk(1'b0, 8'h41, 1'b0, 1'b0, 1'b1);
        vecs[5]  = mk(1'b0, 8'h98, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 8'h98, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(1'b0, 8'h98, 1'b0, 1'b1, 1'b0);
        vecs[8]  = mk(1'b0, 8'h98, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 8'h98, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(1'b1, 8'h98, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(1'b1, 8'h98, 1'b0, 1'b1, 1'b1);
        vecs[12] = mk(1'b1, 8'h38, 1'b0, 1'b0, 1'b1);
        vecs[13] = mk(1'b1, 8'h38, 1'b0, 1'b0, 1'b1);
        vecs[14] = mk(1'b0, 8'h38, 1'b0, 1'b0, 1'b1);
        vecs[15] = mk(1'b0, 8'h38, 1'b0, 1'b1, 1'b1);
        vecs[16] = mk(1'b0, 8'hBB, 1'b1, 1'b0, 1'b0);
        vecs[17] = mk(1'b0, 8'hBB, 1'b0, 1'b0, 1'b0);
        vecs[18] = mk(1'b0, 8'hBB, 1'b0, 1'b0, 1'b0);
        vecs[19] = mk(1'b0, 8'hBB, 1'b0, 1'b1, 1'b0);
        vecs[20] = mk(1'b0, 8'hBB, 1'b0, 1'b0, 1'b0);

        // Reset held with EN toggling.
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            bus_if.en = i[0];
            step();
            check_reset_outputs("rst_hold");
        end

        // Vector table.
        reset_release();
        for (int k = 0; k < 21; k++) begin
            bus_if.en = vecs[k].en;
            step();
            check("tbl.value",   bus_if.value,       vecs[k].value);
            check("tbl.valid",   8'(bus_if.valid),   8'(vecs[k].valid));
            check("tbl.tick",    8'(bus_if.tick),    8'(vecs[k].tick));
            check("tbl.rolling", 8'(bus_if.rolling), 8'(vecs[k].rolling));
        end

        // Divider with EN held low.
        reset_release();
        for (int k = 1; k <= 13; k++) begin
            step();
            check("div.tick",  8'(bus_if.tick), ((k % 4) == 0) ? 8'h01 : 8'h00);
            check("div.value", bus_if.value, 8'h00);
            check("div.rolling", 8'(bus_if.rolling), 8'h00);
        end

        // Animation: EN high for 20 cycles, VALUE follows the reference LFSR on ticks only.
        reset_release();
        bus_if.en = 1'b1;
        m_lfsr  = TB_SEED;
        exp_val = 8'h00;
        for (int k = 1; k <= 20; k++) begin
            if ((k - 1) >= 4 && ((k - 1) % 4) == 0 && (k - 1) >= 3) exp_val = m_lfsr;
            m_lfsr = ref_lfsr(m_lfsr);
            step();
            check("anim.value",   bus_if.value,       exp_val);
            check("anim.valid",   8'(bus_if.valid),   8'h00);
            check("anim.rolling", 8'(bus_if.rolling), (k >= 3) ? 8'h01 : 8'h00);
        end
        check("anim.final", bus_if.value, 8'hBB);

        // Reset mid-roll: asynchronous clear, no VALID, LFSR restarts from the seed.
        reset_release();
        bus_if.en = 1'b1;
        repeat (6) step();
        check("mid.value_before", bus_if.value, 8'h41);
        check("mid.rolling_before", 8'(bus_if.rolling), 8'h01);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("mid_async");
        saw_valid = 1'b0;
        bus_if.en = 1'b0;
        repeat (3) begin
            step();
            if (bus_if.valid) saw_valid = 1'b1;
        end
        check("mid.no_valid", 8'(saw_valid), 8'h00);
        reset_release();
        bus_if.en = 1'b1;
        repeat (3) step();
        bus_if.en = 1'b0;
        repeat (3) step();
        check("mid.rerun_value", bus_if.value, 8'h98);
        check("mid.rerun_valid", 8'(bus_if.valid), 8'h01);
        step();
        check("mid.valid_drop", 8'(bus_if.valid), 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prng_roll_core.md
# prng_roll_core

Random-number source for the two-digit hex dice display. Free-running 8-bit Galois LFSR plus a tick divider and a small roll/hold state machine driven by the EN button. It produces an 8-bit VALUE and strobes, and feeds the downstream hex-to-seven-segment stage that drives HEX0 (VALUE[3:0]) and HEX1 (VALUE[7:4]). It also produces the 1 Hz TICK strobe the display stage uses for animation.

## Interface
- TICK_DIV, 10_000_000: clock cycles per TICK. Must be ≥ 2. The bench uses 4.
- SEED, 8'hA5: LFSR reset and recovery value. Must be non-zero.
- CLK  in  1  system clock, all logic on rising edge.
- RST_N  in  1  asynchronous, active-low reset. Synchronous deassertion is handled at top level.
- EN  in  1  asynchronous roll button. High = rolling, low = hold.
- VALUE  out  8  current displayed number.
- VALID  out  1  one-cycle pulse when a roll result is latched.
- TICK  out  1  one-cycle strobe every TICK_DIV cycles.
- ROLLING  out  1  high while state is ROLL.

## Operation
- **LFSR**
  - Steps on every clock edge from reset, regardless of state.
  - Step rule: if lfsr[0], then lfsr ← (lfsr >> 1) ^ 8'hB8; otherwise lfsr ← lfsr >> 1.
  - Period is 255.
  - If lfsr is ever 8'h00, the next edge loads SEED instead of stepping.
  - Sequence from SEED = A5: A5, EA, 75, 82, 41, 98, …
- **EN synchronizer**
  - Two flops, s1 → s2, followed by delay flop s2_d. All three reset to 0.
  - rise = s2 & ~s2_d; fall = ~s2 & s2_d.
- **Divider**
  - cnt counts 0 … TICK_DIV−1 and wraps. Width is $clog2(TICK_DIV).
  - TICK is registered. It is high during the cycle after the edge on which cnt goes TICK_DIV−1 → 0.
  - The divider is free-running and unaffected by EN or state.
- **States**
  - IDLE (reset state): on rise → ROLL.
  - ROLL: on each cycle with TICK = 1, VALUE ← lfsr (animation). No VALID. On fall: VALUE ← lfsr, VALID ← 1, → SHOW.
  - SHOW: VALUE is held. On rise → ROLL.
  - A fall in IDLE or SHOW, or a rise in ROLL, cannot occur legally. It is ignored with no state change.
- **Simultaneous events**
  - Fall and TICK on the same edge in ROLL: a single latch of lfsr with VALID = 1. The fall takes precedence; the value is identical either way.
- **Reset values**
  - lfsr = SEED, VALUE = 8'h00, VALID = 0, TICK = 0, ROLLING = 0, cnt = 0, state = IDLE.
- **Reset mid-roll**: everything returns to reset values immediately. No VALID is emitted.

## Timing
- EN change between edges n−1 and n: s1 updates at edge n, s2 at edge n+1. The state action occurs at edge n+2.
- VALUE latched on a fall is the pre-step lfsr at the acting edge.
- VALID is high exactly one cycle, the cycle following the acting edge.
- ROLLING changes on the same edge as the state transition.
- First TICK is high after edge TICK_DIV, then after every TICK_DIV edges after that.
- All outputs are registered; no combinational path from EN to any output.

## Structure
- Shared package `prng_pkg`:
  - state enum {IDLE, ROLL, SHOW}
  - LFSR_TAPS = 8'hB8
  - default SEED = 8'hA5
- Sub-module `tick_div` (parameter TICK_DIV; ports CLK, RST_N, TICK). It is reused by the display stage.
- LFSR, synchronizer and FSM stay inline in prng_roll_core.

## Test plan
All scenarios use TICK_DIV = 4 and SEED = A5, with reset released before edge 1.
- **Reset**: hold RST_N = 0 with EN toggling → VALUE = 00, VALID = 0, TICK = 0, ROLLING = 0 throughout.
- **Short roll**: EN = 1 from reset release, dropped between edges 3 and 4 → ROLLING = 1 after edge 3; VALUE = 8'h98 and VALID = 1 after edge 6; ROLLING = 0 after edge 6.
- **Divider**: EN held 0 → TICK high only after edges 4, 8, 12, …; VALUE stays 00.
- **Animation**: EN = 1 for 20 cycles → VALUE updates only on TICK cycles while ROLLING. Each update equals the reference-model lfsr at that edge. VALID stays 0.
- **Re-roll from SHOW**: after a completed roll, raise EN → ROLL two edges later. The old VALUE is held until the first TICK or the next fall.
- **Reset mid-roll**: pulse RST_N low during ROLL → all outputs return to reset values asynchronously. No VALID; lfsr restarts at A5.
